// File: rtl/buffer_pkg.sv
// Shared definitions for buffer_loader: FSM state encoding and the
// on-chip footprint check applied to a requested ifmap width.
package buffer_pkg;

    typedef logic [2:0] loader_state_t;

    localparam loader_state_t S_IDLE = 3'd0;
    localparam loader_state_t S_LOAD = 3'd1;
    localparam loader_state_t S_KICK = 3'd2;
    localparam loader_state_t S_WAIT = 3'd3;
    localparam loader_state_t S_DONE = 3'd4;

    localparam int unsigned MIN_IFMAP_WIDTH = 3;
    localparam int unsigned FOOTPRINT_BITS  = 34;

    // The ifmap (W*W) plus the (W-2)*(W-2) output region must fit in the buffer.
    // 34 bits hold the worst case for a 16-bit W without wrapping.
    function automatic logic [FOOTPRINT_BITS-1:0] footprint(input logic [15:0] w);
        logic [FOOTPRINT_BITS-1:0] wx;
        logic [FOOTPRINT_BITS-1:0] wm;
        wx = {{(FOOTPRINT_BITS-16){1'b0}}, w};
        wm = wx - 34'd2;
        return wx * wx + wm * wm;
    endfunction

endpackage

// File: rtl/buffer_loader.sv
// Streams a square ifmap into a buffer, kicks the router, waits for its
// completion flag. Optional cycle counter: define BUFFER_LOADER_PERF_EN.
module buffer_loader
    import buffer_pkg::*;
#(
    parameter int dataSize    = 8,
    parameter int numRegister = 256,
    localparam int nAddress   = $clog2(numRegister)
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                start_i,
    input  logic [15:0]         cfg_ifmap_width,
    input  logic [dataSize-1:0] in_data_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    output logic [dataSize-1:0] wr_data,
    output logic [nAddress-1:0] wr_addr,
    output logic                wr_en,
    output logic                ctrl_start,
    input  logic                flag_done,
    output logic                busy_o,
    output logic                done_o,
    output logic                cfg_err_o
`ifdef BUFFER_LOADER_PERF_EN
    ,
    output logic [31:0]         perf_cycles_o
`endif
);

    loader_state_t       state;
    logic [31:0]         n_q;
    logic [nAddress-1:0] cnt;
    logic [31:0]         cfg_n;
    logic                cfg_ok;
    logic                xfer;
    logic                last;

    assign cfg_n  = 32'(cfg_ifmap_width) * 32'(cfg_ifmap_width);
    assign cfg_ok = (cfg_ifmap_width >= 16'(MIN_IFMAP_WIDTH)) &&
                    (footprint(cfg_ifmap_width) <= FOOTPRINT_BITS'(numRegister));

    // Handshake: an element moves when in_valid_i && in_ready_o at a rising clk;
    // in_ready_o depends only on state, so it never combinationally follows in_valid_i.
    assign in_ready_o = (state == S_LOAD);
    assign xfer       = in_valid_i && in_ready_o;
    assign last       = (32'(cnt) == n_q - 32'd1);

    assign ctrl_start = (state == S_KICK);
    assign done_o     = (state == S_DONE);
    assign busy_o     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= S_IDLE;
            n_q       <= '0;
            cnt       <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            cfg_err_o <= 1'b0;
        end else begin
            wr_en <= xfer;
            if (xfer) begin
                wr_addr <= cnt;
                wr_data <= in_data_i;
                cnt     <= cnt + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        if (cfg_ok) begin
                            cfg_err_o <= 1'b0;
                            n_q       <= cfg_n;
                            cnt       <= '0;
                            state     <= S_LOAD;
                        end else begin
                            cfg_err_o <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (xfer && last) state <= S_KICK;
                end
                S_KICK: state <= S_WAIT;
                S_WAIT: begin
                    if (flag_done) state <= S_DONE;
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef BUFFER_LOADER_PERF_EN
    // The accepted start cycle counts as 1; every busy cycle through S_DONE adds one.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            perf_cycles_o <= '0;
        end else if (state == S_IDLE) begin
            if (start_i && cfg_ok) perf_cycles_o <= 32'd1;
        end else if (perf_cycles_o != '1) begin
            perf_cycles_o <= perf_cycles_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_buffer_loader.sv
// Directed bench for buffer_loader: scoreboard of expected buffer writes,
// immediate-assertion checks, one summary line at the end.
`timescale 1ns/1ps
module tb_buffer_loader;

    localparam int DW   = 8;
    localparam int NREG = 256;
    localparam int AW   = $clog2(NREG);

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          start_i = 1'b0;
    logic [15:0]   cfg_ifmap_width = 16'd0;
    logic [DW-1:0] in_data_i = '0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic          ctrl_start;
    logic          flag_done = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic          cfg_err_o;
`ifdef BUFFER_LOADER_PERF_EN
    logic [31:0]   perf_cycles_o;
`endif

    buffer_loader dut (
        .clk             (clk),
        .nrst            (nrst),
        .start_i         (start_i),
        .cfg_ifmap_width (cfg_ifmap_width),
        .in_data_i       (in_data_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .wr_data         (wr_data),
        .wr_addr         (wr_addr),
        .wr_en           (wr_en),
        .ctrl_start      (ctrl_start),
        .flag_done       (flag_done),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .cfg_err_o       (cfg_err_o)
`ifdef BUFFER_LOADER_PERF_EN
        ,
        .perf_cycles_o   (perf_cycles_o)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] mon_e;
    int cur_n     = 0;
    int cyc       = 0;
    int start_cyc = 0;
    int done_cyc  = 0;
    int kick_cnt  = 0;
    int done_cnt  = 0;
    int wr_first  = 0;
    int wr_last   = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_cmp++;
        assert (obs === expd) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expd);
        end
    endtask

    // scoreboard: every buffer write must match the oldest expected {addr, data}
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (wr_addr === '0) wr_first = cyc;
            wr_last = cyc;
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(mon_e[AW+DW-1:DW]));
                check("wr_data", 32'(wr_data), 32'(mon_e[DW-1:0]));
            end
        end
        if (ctrl_start === 1'b1) begin
            kick_cnt++;
            check("kick_wr_en", 32'(wr_en), 32'd1);
            check("kick_addr", 32'(wr_addr), 32'(cur_n - 1));
        end
        if (done_o === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // driver tasks
    task automatic send_elem(input logic [DW-1:0] d, input logic [AW-1:0] a, input int gap);
        int guard;
        repeat (gap) begin
            @(negedge clk);
            in_valid_i = 1'b0;
        end
        @(negedge clk);
        in_valid_i = 1'b1;
        in_data_i  = d;
        guard = 0;
        while (in_ready_o !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("ready_timeout", 32'd0, 32'd1);
        else exp_q.push_back({a, d});
    endtask

    task automatic start_job(input int w, input logic ok);
        @(negedge clk);
        start_i = 1'b1;
        cfg_ifmap_width = 16'(w);
        @(negedge clk);
        start_i = 1'b0;
        cfg_ifmap_width = 16'd2;
        if (ok) begin
            cur_n = w * w;
            start_cyc = cyc;
        end
        check("start_busy", 32'(busy_o), 32'(ok));
        check("start_ready", 32'(in_ready_o), 32'(ok));
        check("start_cfg_err", 32'(cfg_err_o), 32'(!ok));
    endtask

    task automatic run_job(input int w, input int gap, input int done_dly, input logic disturb);
        int n;
        n = w * w;
        kick_cnt = 0;
        done_cnt = 0;
        start_job(w, 1'b1);
        for (int i = 0; i < n; i++) begin
            if (disturb && i == n / 2) begin
                start_i = 1'b1;
                flag_done = 1'b1;
                cfg_ifmap_width = 16'd3;
            end
            send_elem(DW'($urandom_range(0, 255)), AW'(i), (i == 0) ? 0 : gap);
            start_i = 1'b0;
            flag_done = 1'b0;
        end
        @(negedge clk);
        in_valid_i = 1'b0;
        check("kick_ctrl_start", 32'(ctrl_start), 32'd1);
        check("kick_ready_low", 32'(in_ready_o), 32'd0);
        repeat (done_dly) begin
            @(negedge clk);
            check("wait_no_done", 32'(done_o), 32'd0);
        end
        flag_done = 1'b1;
        @(negedge clk);
        flag_done = 1'b0;
        check("done_pulse", 32'(done_o), 32'd1);
        check("done_busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        check("done_low", 32'(done_o), 32'd0);
        check("idle_busy", 32'(busy_o), 32'd0);
        check("kick_count", 32'(kick_cnt), 32'd1);
        check("done_count", 32'(done_cnt), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        if (gap == 0) check("contig_span", 32'(wr_last - wr_first), 32'(n - 1));
`ifdef BUFFER_LOADER_PERF_EN
        check("perf_cycles", perf_cycles_o, 32'(done_cyc - start_cyc + 1));
        repeat (3) @(negedge clk);
        check("perf_hold", perf_cycles_o, 32'(done_cyc - start_cyc + 1));
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(in_ready_o), 32'd0);
        check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check({tag, "_ctrl_start"}, 32'(ctrl_start), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_cfg_err"}, 32'(cfg_err_o), 32'd0);
`ifdef BUFFER_LOADER_PERF_EN
        check({tag, "_perf"}, perf_cycles_o, 32'd0);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset state
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        nrst = 1'b1;

        // W=5, continuous stream, router completes 10 cycles after the kick
        run_job(5, 0, 10, 1'b0);

        // W=4, valid toggling 1,0,0,1,...
        run_job(4, 2, 3, 1'b0);

        // rejected widths, then the largest width that fits
        start_job(2, 1'b0);
        repeat (5) begin
            @(negedge clk);
            check("reject_no_wr", 32'(wr_en), 32'd0);
            check("reject_idle", 32'(busy_o), 32'd0);
        end
        start_job(13, 1'b0);
        check("reject13_err", 32'(cfg_err_o), 32'd1);
        run_job(12, 0, 2, 1'b0);

        // smallest accepted width, with a stray start and flag_done mid-load
        run_job(3, 0, 5, 1'b0);
        run_job(4, 0, 4, 1'b1);

        // reset right after the addr-7 write of a W=5 job, then restart
        start_job(5, 1'b1);
        for (int i = 0; i < 8; i++) send_elem(DW'($urandom_range(0, 255)), AW'(i), 0);
        @(negedge clk);
        in_valid_i = 1'b0;
        nrst = 1'b0;
        @(negedge clk);
        check_all_zero("midjob_reset");
        check("midjob_queue", 32'(exp_q.size()), 32'd0);
        nrst = 1'b1;
        kick_cnt = 0;
        repeat (3) @(negedge clk);
        check("midjob_no_kick", 32'(kick_cnt), 32'd0);
        run_job(5, 1, 6, 1'b0);

        @(negedge clk);
        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
